// File: rtl/divider_pkg.sv
// Shared definitions for the 32/16 restoring divider: operand widths,
// iteration count and controller state encoding.
package divider_pkg;

    localparam int unsigned DIVIDEND_W = 32;
    localparam int unsigned DIVISOR_W  = 16;
    localparam int unsigned ITER_COUNT = 16;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle of the divider; slave side is the divider itself.
interface divider_if;
    import divider_pkg::*;

    logic                  start;
    logic                  signed_op;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVISOR_W-1:0]  quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_zero;
    logic                  v;
    logic                  z;
    logic                  n;
    logic                  c;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, v, z, n, c
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, v, z, n, c
    );

endinterface

// File: rtl/divider_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference when there is no borrow.
module divider_divstep
    import divider_pkg::*;
(
    input  logic [DIVISOR_W:0]   i_pr,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_pr,
    output logic                 o_qbit
);
    logic [DIVISOR_W:0]   w_shift;
    logic [DIVISOR_W+1:0] w_trial;
    logic                 w_unused;

    // The partial remainder entering a step is always below the divisor, so its MSB is zero.
    assign w_unused = i_pr[DIVISOR_W];
    assign w_shift  = {i_pr[DIVISOR_W-1:0], i_bit};
    assign w_trial  = {1'b0, w_shift} - {2'b00, i_divisor};
    assign o_qbit   = ~w_trial[DIVISOR_W+1];
    assign o_pr     = o_qbit ? w_trial[DIVISOR_W:0] : w_shift;

endmodule

// File: rtl/divider.sv
// 32/16 sequential divider, signed or unsigned, one quotient bit per cycle,
// with early exit on divide-by-zero and on quotient overflow.
module divider
    import divider_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    divider_if.slave bus
);
    state_t                r_state;
    state_t                w_next_state;
    logic                  w_busy;
    logic                  w_done;

    logic                  r_signed;
    logic [DIVIDEND_W-1:0] r_dividend;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W:0]    r_pr;
    logic [DIVISOR_W-1:0]  r_qsh;
    logic [CNT_W-1:0]      r_cnt;

    logic [DIVISOR_W-1:0]  r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_zero;
    logic                  r_v;
    logic                  r_z;
    logic                  r_n;

    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dvs_mag;
    logic                  w_q_neg;
    logic                  w_r_neg;
    logic                  w_zero;
    logic                  w_ovf_early;
    logic                  w_ovf_fix;
    logic [DIVISOR_W-1:0]  w_q_final;
    logic [DIVISOR_W-1:0]  w_r_final;
    logic [DIVISOR_W:0]    w_step_pr;
    logic                  w_step_qbit;

    // Signed mode runs on magnitudes; signs are restored in FIX.
    assign w_dvd_mag   = (r_signed && r_dividend[DIVIDEND_W-1]) ? (~r_dividend + 32'd1) : r_dividend;
    assign w_dvs_mag   = (r_signed && r_divisor[DIVISOR_W-1])   ? (~r_divisor + 16'd1)  : r_divisor;
    assign w_q_neg     = r_signed & (r_dividend[DIVIDEND_W-1] ^ r_divisor[DIVISOR_W-1]);
    assign w_r_neg     = r_signed & r_dividend[DIVIDEND_W-1];
    assign w_zero      = (r_divisor == '0);
    assign w_ovf_early = (w_dvd_mag[DIVIDEND_W-1:DIVISOR_W] >= w_dvs_mag);

    assign w_ovf_fix = r_signed & (w_q_neg ? (r_qsh > 16'h8000) : (r_qsh > 16'h7FFF));
    assign w_q_final = w_q_neg ? (~r_qsh + 16'd1) : r_qsh;
    assign w_r_final = w_r_neg ? (~r_pr[DIVISOR_W-1:0] + 16'd1) : r_pr[DIVISOR_W-1:0];

    divider_divstep u_step (
        .i_pr      (r_pr),
        .i_bit     (r_qsh[DIVISOR_W-1]),
        .i_divisor (w_dvs_mag),
        .o_pr      (w_step_pr),
        .o_qbit    (w_step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next_state = S_CHECK;
            end
            S_CHECK: begin
                w_busy       = 1'b1;
                w_next_state = (w_zero || w_ovf_early) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(ITER_COUNT - 1)) w_next_state = S_FIX;
            end
            S_FIX: begin
                w_busy       = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = bus.start ? S_CHECK : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signed    <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_pr        <= '0;
            r_qsh       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_v         <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_signed   <= bus.signed_op;
                        r_dividend <= bus.dividend;
                        r_divisor  <= bus.divisor;
                    end
                end
                S_CHECK: begin
                    r_pr  <= {1'b0, w_dvd_mag[DIVIDEND_W-1:DIVISOR_W]};
                    r_qsh <= w_dvd_mag[DIVISOR_W-1:0];
                    r_cnt <= '0;
                    if (w_zero || w_ovf_early) begin
                        r_div_zero <= w_zero;
                        r_v        <= ~w_zero;
                        r_z        <= 1'b0;
                        r_n        <= 1'b0;
                    end
                end
                S_ITER: begin
                    r_pr  <= w_step_pr;
                    r_qsh <= {r_qsh[DIVISOR_W-2:0], w_step_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_div_zero <= 1'b0;
                    if (w_ovf_fix) begin
                        r_v <= 1'b1;
                        r_z <= 1'b0;
                        r_n <= 1'b0;
                    end else begin
                        r_quotient  <= w_q_final;
                        r_remainder <= w_r_final;
                        r_v         <= 1'b0;
                        r_z         <= (w_q_final == '0);
                        r_n         <= w_q_final[DIVISOR_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;
    assign bus.v         = r_v;
    assign bus.z         = r_z;
    assign bus.n         = r_n;
    assign bus.c         = 1'b0;

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: Divider

Interface
REQ-001 Divider SHALL have no parameters; widths are fixed at 32-bit dividend and 16-bit divisor, quotient and remainder.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only when the block is ready.
REQ-005 signed_op  input  1  1 = signed divide, 0 = unsigned; captured with start.
REQ-006 dividend  input  32  captured with start.
REQ-007 divisor  input  16  captured with start.
REQ-008 busy  output  1  high in CHECK, ITER and FIX.
REQ-009 done  output  1  one-cycle pulse marking a completed operation.
REQ-010 quotient  output  16  result quotient, registered.
REQ-011 remainder  output  16  result remainder, registered.
REQ-012 div_zero  output  1  divisor was zero; valid with done.
REQ-013 V, Z, N, C  output  1 each  condition flags; valid with done.

Function
REQ-014 States SHALL be IDLE, CHECK, ITER, FIX and DONE.
REQ-015 start SHALL be accepted only in IDLE or DONE; operands and signed_op are latched; next state is CHECK.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unless a new start is accepted.
REQ-018 In signed mode the datapath SHALL use magnitudes: quotient sign = dividend[31] xor divisor[15]; remainder sign = dividend[31].
REQ-019 In CHECK, a zero divisor SHALL go to DONE with div_zero=1 and V=Z=N=C=0; quotient and remainder hold their previous values.
REQ-020 In CHECK, |dividend|[31:16] >= |divisor| SHALL go to DONE with V=1 and Z=N=C=0; quotient and remainder hold.
REQ-021 Otherwise ITER SHALL run exactly 16 cycles of restoring division, one quotient bit per cycle, MSB first.
REQ-022 Each ITER step SHALL do a 17-bit trial subtraction of the divisor magnitude from the shifted partial remainder; it commits when there is no borrow.
REQ-023 FIX SHALL apply sign correction.
REQ-024 In signed mode FIX SHALL set V=1 when the quotient magnitude exceeds 32767 for a positive result or 32768 for a negative result; results then hold.
REQ-025 Without overflow, FIX SHALL load quotient and remainder and set N=quotient[15], Z=(quotient==0), V=0, C=0.
REQ-026 C SHALL always be 0.
REQ-027 Latency: start accepted at edge 0 SHALL give done=1 in cycle 19 on the full path and in cycle 2 on the early-exit path.
REQ-028 Outputs SHALL change only on entry to DONE.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0 and V=Z=N=C=0.
REQ-030 Reset in any state, including mid-ITER, SHALL abandon the operation; no done pulse follows.

Structure
REQ-031 A shared include file SHALL hold the state encoding, the ITER count constant (16) and the operand widths.
REQ-032 A single sub-module DivStep SHALL implement one shift/trial-subtract/select step: 17-bit partial remainder in, next partial remainder and quotient bit out.
REQ-033 Iteration counter, sign handling and flag logic SHALL stay in Divider.

Verification
REQ-034 Unsigned 100 / 7 -> quotient=14, remainder=2, V=Z=N=C=0, div_zero=0, done in cycle 19.
REQ-035 Any dividend, divisor=0 -> div_zero=1, done in cycle 2, quotient and remainder unchanged.
REQ-036 Unsigned 0x00010000 / 1 -> V=1, done in cycle 2, results unchanged; signed 0xFFFF8000 / 0xFFFF -> V=1, done in cycle 19.
REQ-037 Signed 0xFFFFFF9C (-100) / 7 -> quotient=0xFFF2, remainder=0xFFFE, N=1, Z=0, V=0.
REQ-038 Unsigned 5 / 7 -> quotient=0, remainder=5, Z=1; start pulsed at cycle 5 is ignored; start in the DONE cycle launches a back-to-back operation.
REQ-039 rst_n low during ITER cycle 8 -> busy=0, all outputs 0, no done pulse; a new start after reset completes normally.
